// File: rtl/control_unit_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control unit:
// state codes, instruction classes, ALU op codes and datapath select values.
package control_unit_pkg;

   // State code doubles as the ramAddress trace value.
   typedef enum logic [8:0] {
      S_RESET    = 9'd0,
      S_FETCH0   = 9'd1,
      S_FETCH1   = 9'd2,
      S_FETCH2   = 9'd3,
      S_DECODE   = 9'd4,
      S_EXEC_R   = 9'd5,
      S_EXEC_I   = 9'd6,
      S_WB       = 9'd7,
      S_MEM_ADDR = 9'd8,
      S_MEM_RD   = 9'd9,
      S_MEM_WB   = 9'd10,
      S_MEM_WR   = 9'd11,
      S_BRANCH   = 9'd12,
      S_JUMP     = 9'd13,
      S_INT      = 9'd14
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,  ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,  ALU_NOR  = 4'd5,  ALU_SLL  = 4'd6,  ALU_SRL  = 4'd7,
      ALU_SRA  = 4'd8,  ALU_SLT  = 4'd9,  ALU_PASSA = 4'd10, ALU_PASSB = 4'd11,
      ALU_LUI  = 4'd12, ALU_MULT = 4'd13, ALU_DIV  = 4'd14
   } alu_op_t;

   typedef enum logic [3:0] {
      CLS_NOP    = 4'd0,
      CLS_R      = 4'd1,
      CLS_MULDIV = 4'd2,
      CLS_I      = 4'd3,
      CLS_LOAD   = 4'd4,
      CLS_STORE  = 4'd5,
      CLS_BEQ    = 4'd6,
      CLS_BNE    = 4'd7,
      CLS_J      = 4'd8
   } cls_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04, OP_BNE = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20, OP_LH   = 6'h21, OP_LW   = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24, OP_LHU  = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
   localparam logic [5:0] FN_MULT = 6'h18, FN_DIV  = 6'h1A;
   localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

   localparam logic [1:0] SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
   localparam logic [1:0] SGN_UNS = 2'b00, SGN_SIG = 2'b01;
   localparam logic [1:0] MUX_RT  = 2'b00, MUX_IMM = 2'b01, MUX_PC4 = 2'b10, MUX_BR = 2'b11;

   typedef struct packed {
      cls_t       cls;
      alu_op_t    op;
      logic [1:0] sign;
      logic [1:0] size;
      logic       sext;
   } dec_t;

   typedef struct packed {
      logic       rf_rw;
      logic [4:0] rd;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [1:0] sign;
      alu_op_t    op;
      logic [1:0] size;
      logic       mfa;
      logic       ram_rw;
      logic       rf_en;
      logic       pc_en;
      logic       ir_en;
      logic       mar_en;
      logic       mdr_en;
      logic [1:0] mux1;
      logic       mux2;
      logic       mux3;
      logic       mux4;
   } ctrl_t;

   function automatic logic [4:0] fld_rs(input logic [31:0] i);
      return i[25:21];
   endfunction

   function automatic logic [4:0] fld_rt(input logic [31:0] i);
      return i[20:16];
   endfunction

   function automatic logic [4:0] fld_rd(input logic [31:0] i);
      return i[15:11];
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Datapath-facing bundle of the control unit: instruction/status in, controls out.
interface control_unit_if;
   logic [31:0] instruction;
   logic [3:0]  aluCarryFlags;
   logic        ramMFC;
   logic        hardwareInterrupt;
   logic        maskableInterrupt;
   logic        regFileRW;
   logic [4:0]  regFileRD;
   logic [4:0]  regFileRS;
   logic [4:0]  regFileRT;
   logic [1:0]  aluSign;
   logic [3:0]  aluOperation;
   logic [1:0]  ramDataSize;
   logic        ramMFA;
   logic        ramRW;
   logic [8:0]  ramAddress;
   logic        regFileEnable;
   logic        pcEnable;
   logic        irEnable;
   logic        marEnable;
   logic        mdrEnable;
   logic [1:0]  muxSignals;
   logic        muxSignals2;
   logic        muxSignals3;
   logic        muxSignals4;

   modport master (
      input  instruction, aluCarryFlags, ramMFC, hardwareInterrupt, maskableInterrupt,
      output regFileRW, regFileRD, regFileRS, regFileRT, aluSign, aluOperation,
             ramDataSize, ramMFA, ramRW, ramAddress, regFileEnable, pcEnable,
             irEnable, marEnable, mdrEnable, muxSignals, muxSignals2, muxSignals3,
             muxSignals4
   );

   modport slave (
      output instruction, aluCarryFlags, ramMFC, hardwareInterrupt, maskableInterrupt,
      input  regFileRW, regFileRD, regFileRS, regFileRT, aluSign, aluOperation,
             ramDataSize, ramMFA, ramRW, ramAddress, regFileEnable, pcEnable,
             irEnable, marEnable, mdrEnable, muxSignals, muxSignals2, muxSignals3,
             muxSignals4
   );
endinterface

// File: rtl/control_unit_instr_decoder.sv
// Maps the IR word to an instruction class plus ALU op, signedness, access
// size and immediate extension; unsupported encodings decode as NOP.
module instr_decoder
   import control_unit_pkg::*;
(
   input  logic [31:0] instruction,
   output dec_t        dec
);
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       unused_fields;

   assign opcode        = instruction[31:26];
   assign funct         = instruction[5:0];
   assign unused_fields = ^instruction[25:6];

   always_comb begin
      dec = '{cls: CLS_NOP, op: ALU_ADD, sign: SGN_UNS, size: SZ_WORD, sext: 1'b0};
      case (opcode)
         OP_RTYPE: begin
            dec.cls = CLS_R;
            case (funct)
               FN_ADD:  begin dec.op = ALU_ADD; dec.sign = SGN_SIG; end
               FN_ADDU: dec.op = ALU_ADD;
               FN_SUB:  begin dec.op = ALU_SUB; dec.sign = SGN_SIG; end
               FN_SUBU: dec.op = ALU_SUB;
               FN_AND:  dec.op = ALU_AND;
               FN_OR:   dec.op = ALU_OR;
               FN_XOR:  dec.op = ALU_XOR;
               FN_NOR:  dec.op = ALU_NOR;
               FN_SLT:  begin dec.op = ALU_SLT; dec.sign = SGN_SIG; end
               FN_SLTU: dec.op = ALU_SLT;
               FN_SLL:  dec.op = ALU_SLL;
               FN_SRL:  dec.op = ALU_SRL;
               FN_SRA:  dec.op = ALU_SRA;
               FN_MULT: begin dec.cls = CLS_MULDIV; dec.op = ALU_MULT; dec.sign = SGN_SIG; end
               FN_DIV:  begin dec.cls = CLS_MULDIV; dec.op = ALU_DIV;  dec.sign = SGN_SIG; end
               default: dec.cls = CLS_NOP;
            endcase
         end
         OP_ADDI:  begin dec.cls = CLS_I; dec.op = ALU_ADD; dec.sign = SGN_SIG; dec.sext = 1'b1; end
         OP_ADDIU: begin dec.cls = CLS_I; dec.op = ALU_ADD; dec.sext = 1'b1; end
         OP_SLTI:  begin dec.cls = CLS_I; dec.op = ALU_SLT; dec.sign = SGN_SIG; dec.sext = 1'b1; end
         OP_ANDI:  begin dec.cls = CLS_I; dec.op = ALU_AND; end
         OP_ORI:   begin dec.cls = CLS_I; dec.op = ALU_OR;  end
         OP_XORI:  begin dec.cls = CLS_I; dec.op = ALU_XOR; end
         OP_LUI:   begin dec.cls = CLS_I; dec.op = ALU_LUI; end
         OP_LB:    begin dec.cls = CLS_LOAD; dec.size = SZ_BYTE; dec.sign = SGN_SIG; dec.sext = 1'b1; end
         OP_LBU:   begin dec.cls = CLS_LOAD; dec.size = SZ_BYTE; dec.sext = 1'b1; end
         OP_LH:    begin dec.cls = CLS_LOAD; dec.size = SZ_HALF; dec.sign = SGN_SIG; dec.sext = 1'b1; end
         OP_LHU:   begin dec.cls = CLS_LOAD; dec.size = SZ_HALF; dec.sext = 1'b1; end
         OP_LW:    begin dec.cls = CLS_LOAD; dec.size = SZ_WORD; dec.sext = 1'b1; end
         OP_SB:    begin dec.cls = CLS_STORE; dec.size = SZ_BYTE; dec.sext = 1'b1; end
         OP_SH:    begin dec.cls = CLS_STORE; dec.size = SZ_HALF; dec.sext = 1'b1; end
         OP_SW:    begin dec.cls = CLS_STORE; dec.size = SZ_WORD; dec.sext = 1'b1; end
         OP_BEQ:   begin dec.cls = CLS_BEQ; dec.op = ALU_SUB; end
         OP_BNE:   begin dec.cls = CLS_BNE; dec.op = ALU_SUB; end
         OP_J:     dec.cls = CLS_J;
         default:  dec.cls = CLS_NOP;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: fetch/decode/execute/memory/write-back FSM with
// Moore outputs decoded from the state register and the IR fields.
module control_unit
   import control_unit_pkg::*;
(
   input  logic           Clk,
   input  logic           reset,
   control_unit_if.master bus
);
   state_t     state_q, state_d;
   logic       phase_q, phase_d;
   logic       take_q, take_d;
   logic       ie_q, ie_d;
   dec_t       dec;
   ctrl_t      ctl;
   logic [4:0] rs_f, rt_f, rd_f, dest;
   logic       z_flag, int_req;
   logic       unused_bits;

   instr_decoder u_dec (
      .instruction (bus.instruction),
      .dec         (dec)
   );

   assign rs_f        = fld_rs(bus.instruction);
   assign rt_f        = fld_rt(bus.instruction);
   assign rd_f        = fld_rd(bus.instruction);
   assign z_flag      = bus.aluCarryFlags[2];
   assign int_req     = bus.hardwareInterrupt | (bus.maskableInterrupt & ie_q);
   assign dest        = (dec.cls == CLS_I) ? rt_f : rd_f;
   assign unused_bits = ^{bus.aluCarryFlags[3], bus.aluCarryFlags[1:0], bus.instruction[10:6]};

   // MEM_ADDR and BRANCH each take two cycles; phase_q tracks which half.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      take_d  = take_q;
      ie_d    = ie_q;
      case (state_q)
         S_RESET:  state_d = S_FETCH0;
         S_FETCH0: begin
            if (int_req) begin
               state_d = S_INT;
               ie_d    = 1'b0;
            end else begin
               state_d = S_FETCH1;
            end
         end
         S_FETCH1: if (bus.ramMFC) state_d = S_FETCH2;
         S_FETCH2: state_d = S_DECODE;
         S_DECODE: begin
            phase_d = 1'b0;
            case (dec.cls)
               CLS_R, CLS_MULDIV:   state_d = S_EXEC_R;
               CLS_I:               state_d = S_EXEC_I;
               CLS_LOAD, CLS_STORE: state_d = S_MEM_ADDR;
               CLS_BEQ, CLS_BNE:    state_d = S_BRANCH;
               CLS_J:               state_d = S_JUMP;
               default:             state_d = S_FETCH0;
            endcase
         end
         S_EXEC_R: state_d = (dec.cls == CLS_MULDIV) ? S_FETCH0 : S_WB;
         S_EXEC_I: state_d = S_WB;
         S_WB:     state_d = S_FETCH0;
         S_MEM_ADDR: begin
            phase_d = ~phase_q;
            if (phase_q) state_d = (dec.cls == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: if (bus.ramMFC) state_d = S_MEM_WB;
         S_MEM_WB: state_d = S_FETCH0;
         S_MEM_WR: if (bus.ramMFC) state_d = S_FETCH0;
         S_BRANCH: begin
            phase_d = ~phase_q;
            if (!phase_q) take_d = (dec.cls == CLS_BEQ) ? z_flag : ~z_flag;
            else          state_d = S_FETCH0;
         end
         S_JUMP:   state_d = S_FETCH0;
         S_INT:    state_d = S_FETCH0;
         default:  state_d = S_FETCH0;
      endcase
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_RESET;
         phase_q <= 1'b0;
         take_q  <= 1'b0;
         ie_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         take_q  <= take_d;
         ie_q    <= ie_d;
      end
   end

   // WB keeps the execute-stage operand selects so the ALU result stays valid.
   always_comb begin
      ctl = '0;
      case (state_q)
         S_FETCH0: ctl.mar_en = 1'b1;
         S_FETCH1: begin
            ctl.mfa    = 1'b1;
            ctl.ram_rw = 1'b1;
            ctl.size   = SZ_WORD;
            ctl.mdr_en = 1'b1;
         end
         S_FETCH2: begin
            ctl.ir_en = 1'b1;
            ctl.pc_en = 1'b1;
            ctl.mux1  = MUX_PC4;
            ctl.op    = ALU_ADD;
         end
         S_EXEC_R, S_EXEC_I, S_WB: begin
            ctl.rs   = rs_f;
            ctl.op   = dec.op;
            ctl.sign = dec.sign;
            if (dec.cls == CLS_I) begin
               ctl.mux1 = MUX_IMM;
               ctl.mux4 = dec.sext;
               ctl.rd   = rt_f;
            end else begin
               ctl.rt   = rt_f;
               ctl.mux1 = MUX_RT;
               ctl.mux3 = (dec.cls == CLS_MULDIV);
               ctl.rd   = (dec.cls == CLS_MULDIV) ? 5'd0 : rd_f;
            end
            if (state_q == S_WB) begin
               ctl.rf_en = 1'b1;
               ctl.rf_rw = (dest != 5'd0);
            end
         end
         S_MEM_ADDR: begin
            ctl.rs     = rs_f;
            ctl.mux1   = MUX_IMM;
            ctl.mux4   = 1'b1;
            ctl.op     = ALU_ADD;
            ctl.mar_en = 1'b1;
            ctl.sign   = dec.sign;
         end
         S_MEM_RD: begin
            ctl.mfa    = 1'b1;
            ctl.ram_rw = 1'b1;
            ctl.mdr_en = 1'b1;
            ctl.size   = dec.size;
            ctl.sign   = dec.sign;
         end
         S_MEM_WB: begin
            ctl.rf_en = 1'b1;
            ctl.rd    = rt_f;
            ctl.rf_rw = (rt_f != 5'd0);
            ctl.size  = dec.size;
            ctl.sign  = dec.sign;
         end
         S_MEM_WR: begin
            ctl.rt     = rt_f;
            ctl.mux2   = 1'b1;
            ctl.mdr_en = 1'b1;
            ctl.mfa    = 1'b1;
            ctl.size   = dec.size;
            ctl.sign   = dec.sign;
         end
         S_BRANCH: begin
            if (!phase_q) begin
               ctl.rs   = rs_f;
               ctl.rt   = rt_f;
               ctl.op   = ALU_SUB;
               ctl.mux1 = MUX_RT;
            end else if (take_q) begin
               ctl.pc_en = 1'b1;
               ctl.mux1  = MUX_BR;
               ctl.mux4  = 1'b1;
               ctl.op    = ALU_ADD;
            end
         end
         S_JUMP: ctl.pc_en = 1'b1;
         S_INT: begin
            ctl.pc_en = 1'b1;
            ctl.op    = ALU_PASSB;
         end
         default: ;
      endcase
   end

   assign bus.regFileRW     = ctl.rf_rw;
   assign bus.regFileRD     = ctl.rd;
   assign bus.regFileRS     = ctl.rs;
   assign bus.regFileRT     = ctl.rt;
   assign bus.aluSign       = ctl.sign;
   assign bus.aluOperation  = ctl.op;
   assign bus.ramDataSize   = ctl.size;
   assign bus.ramMFA        = ctl.mfa;
   assign bus.ramRW         = ctl.ram_rw;
   assign bus.ramAddress    = state_q;
   assign bus.regFileEnable = ctl.rf_en;
   assign bus.pcEnable      = ctl.pc_en;
   assign bus.irEnable      = ctl.ir_en;
   assign bus.marEnable     = ctl.mar_en;
   assign bus.mdrEnable     = ctl.mdr_en;
   assign bus.muxSignals    = ctl.mux1;
   assign bus.muxSignals2   = ctl.mux2;
   assign bus.muxSignals3   = ctl.mux3;
   assign bus.muxSignals4   = ctl.mux4;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle output table plus hand-written
// MFC-stall, interrupt and asynchronous-reset sequences.
module tb_control_unit;
   logic Clk;
   logic reset;

   control_unit_if cif();

   control_unit dut (
      .Clk   (Clk),
      .reset (reset),
      .bus   (cif)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [8:0] st;
      logic [4:0] en;   // {regFile, pc, ir, mar, mdr}
      logic       mfa;
      logic       rrw;
      logic [1:0] size;
      logic       rfrw;
      logic [4:0] rd;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [3:0] op;
      logic [1:0] sign;
      logic [1:0] mux;
      logic       m2;
      logic       m3;
      logic       m4;
   } snap_t;

   typedef struct {
      logic [31:0] instr;
      logic        z;
      snap_t       exp;
   } vec_t;

   vec_t  tv[$];
   int    n_chk = 0;
   int    n_pass = 0;
   snap_t s_f0, s_f1, s_f2, s_dec, s_int;

   localparam logic [31:0] I_ADD  = 32'h00221820;
   localparam logic [31:0] I_LB   = 32'h82000000;
   localparam logic [31:0] I_SW   = 32'hACC50004;
   localparam logic [31:0] I_ORI  = 32'h34071234;
   localparam logic [31:0] I_MULT = 32'h01090018;
   localparam logic [31:0] I_NOP  = 32'hFC000000;
   localparam logic [31:0] I_BEQ  = 32'h10210003;
   localparam logic [31:0] I_J    = 32'h08000010;

   function automatic snap_t mk(input int st, input int en, input int mfa, input int rrw,
                                input int size, input int rfrw, input int rd, input int rs,
                                input int rt, input int op, input int sign, input int mux,
                                input int m2, input int m3, input int m4);
      snap_t s;
      s.st = 9'(st);     s.en = 5'(en);     s.mfa = 1'(mfa);   s.rrw = 1'(rrw);
      s.size = 2'(size); s.rfrw = 1'(rfrw); s.rd = 5'(rd);     s.rs = 5'(rs);
      s.rt = 5'(rt);     s.op = 4'(op);     s.sign = 2'(sign); s.mux = 2'(mux);
      s.m2 = 1'(m2);     s.m3 = 1'(m3);     s.m4 = 1'(m4);
      return s;
   endfunction

   function automatic snap_t sample();
      snap_t s;
      s.st   = cif.ramAddress;
      s.en   = {cif.regFileEnable, cif.pcEnable, cif.irEnable, cif.marEnable, cif.mdrEnable};
      s.mfa  = cif.ramMFA;
      s.rrw  = cif.ramRW;
      s.size = cif.ramDataSize;
      s.rfrw = cif.regFileRW;
      s.rd   = cif.regFileRD;
      s.rs   = cif.regFileRS;
      s.rt   = cif.regFileRT;
      s.op   = cif.aluOperation;
      s.sign = cif.aluSign;
      s.mux  = cif.muxSignals;
      s.m2   = cif.muxSignals2;
      s.m3   = cif.muxSignals3;
      s.m4   = cif.muxSignals4;
      return s;
   endfunction

   task automatic check(input string name, input snap_t exp);
      snap_t act;
      act = sample();
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got state=%0d bits=%h, want state=%0d bits=%h",
                    name, act.st, act, exp.st, exp);
   endtask

   task automatic add(input logic [31:0] instr, input logic z, input snap_t exp);
      vec_t v;
      v.instr = instr;
      v.z     = z;
      v.exp   = exp;
      tv.push_back(v);
   endtask

   task automatic add_fetch(input logic [31:0] instr);
      add(instr, 1'b0, s_f0);
      add(instr, 1'b0, s_f1);
      add(instr, 1'b0, s_f2);
      add(instr, 1'b0, s_dec);
   endtask

   initial begin
      //        st en       mfa rrw sz rfrw rd rs rt op sg mux m2 m3 m4
      s_f0  = mk(1, 5'b00010, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0);
      s_f1  = mk(2, 5'b00001, 1, 1, 2, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0);
      s_f2  = mk(3, 5'b01100, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2,  0, 0, 0);
      s_dec = mk(4, 5'b00000, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0);
      s_int = mk(14, 5'b01000, 0, 0, 0, 0, 0, 0, 0, 11, 0, 0, 0, 0, 0);

      add(I_ADD, 1'b0, '0);
      add_fetch(I_ADD);
      add(I_ADD, 1'b0, mk(5, 5'b00000, 0, 0, 0, 0, 3, 1, 2, 0, 1, 0, 0, 0, 0));
      add(I_ADD, 1'b0, mk(7, 5'b10000, 0, 0, 0, 1, 3, 1, 2, 0, 1, 0, 0, 0, 0));
      add_fetch(I_LB);
      add(I_LB, 1'b0, mk(8, 5'b00010, 0, 0, 0, 0, 0, 16, 0, 0, 1, 1, 0, 0, 1));
      add(I_LB, 1'b0, mk(8, 5'b00010, 0, 0, 0, 0, 0, 16, 0, 0, 1, 1, 0, 0, 1));
      add(I_LB, 1'b0, mk(9, 5'b00001, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      add(I_LB, 1'b0, mk(10, 5'b10000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      add_fetch(I_SW);
      add(I_SW, 1'b0, mk(8, 5'b00010, 0, 0, 0, 0, 0, 6, 0, 0, 0, 1, 0, 0, 1));
      add(I_SW, 1'b0, mk(8, 5'b00010, 0, 0, 0, 0, 0, 6, 0, 0, 0, 1, 0, 0, 1));
      add(I_SW, 1'b0, mk(11, 5'b00001, 1, 0, 2, 0, 0, 0, 5, 0, 0, 0, 1, 0, 0));
      add_fetch(I_ORI);
      add(I_ORI, 1'b0, mk(6, 5'b00000, 0, 0, 0, 0, 7, 0, 0, 3, 0, 1, 0, 0, 0));
      add(I_ORI, 1'b0, mk(7, 5'b10000, 0, 0, 0, 1, 7, 0, 0, 3, 0, 1, 0, 0, 0));
      add_fetch(I_MULT);
      add(I_MULT, 1'b0, mk(5, 5'b00000, 0, 0, 0, 0, 0, 8, 9, 13, 1, 0, 0, 1, 0));
      add_fetch(I_NOP);
      add_fetch(I_BEQ);
      add(I_BEQ, 1'b1, mk(12, 5'b00000, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
      add(I_BEQ, 1'b0, mk(12, 5'b01000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1));
      add_fetch(I_BEQ);
      add(I_BEQ, 1'b0, mk(12, 5'b00000, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
      add(I_BEQ, 1'b0, mk(12, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add_fetch(I_J);
      add(I_J, 1'b0, mk(13, 5'b01000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(I_NOP, 1'b0, s_f0);

      reset                 = 1'b0;
      cif.instruction       = '0;
      cif.aluCarryFlags     = '0;
      cif.ramMFC            = 1'b0;
      cif.hardwareInterrupt = 1'b0;
      cif.maskableInterrupt = 1'b0;
      @(negedge Clk);
      #1 check("reset_hold", '0);
      reset = 1'b1;

      for (int i = 0; i < tv.size(); i++) begin
         cif.instruction   = tv[i].instr;
         cif.aluCarryFlags = {1'b0, tv[i].z, 2'b00};
         cif.ramMFC        = 1'b1;
         #1 check($sformatf("vec%0d", i), tv[i].exp);
         @(negedge Clk);
      end

      // Now in FETCH1: memory holds off MFC for five cycles.
      cif.instruction   = I_NOP;
      cif.aluCarryFlags = '0;
      for (int k = 0; k < 5; k++) begin
         cif.ramMFC = 1'b0;
         #1 check($sformatf("mfc_wait%0d", k), s_f1);
         @(negedge Clk);
      end
      cif.ramMFC = 1'b1;
      #1 check("mfc_last", s_f1);
      @(negedge Clk);
      #1 check("mfc_f2", s_f2);
      @(negedge Clk);
      #1 check("nop_dec", s_dec);
      @(negedge Clk);

      // Both interrupt lines at FETCH0: NMI wins and IE is cleared.
      cif.hardwareInterrupt = 1'b1;
      cif.maskableInterrupt = 1'b1;
      #1 check("int_f0", s_f0);
      @(negedge Clk);
      cif.hardwareInterrupt = 1'b0;
      #1 check("nmi_int", s_int);
      @(negedge Clk);
      #1 check("int_ret", s_f0);
      @(negedge Clk);
      cif.ramMFC = 1'b0;
      #1 check("mi_ignored", s_f1);

      // Asynchronous reset in the middle of FETCH1 restores IE.
      #2 reset = 1'b0;
      #1 check("rst_async", '0);
      @(negedge Clk);
      #1 check("rst_held", '0);
      reset = 1'b1;
      #1 check("rst_rel", '0);
      @(negedge Clk);
      #1 check("mi_f0", s_f0);
      @(negedge Clk);
      cif.maskableInterrupt = 1'b0;
      #1 check("mi_taken", s_int);
      @(negedge Clk);
      #1 check("mi_done", s_f0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
